// File: rtl/mdu_ctrl.sv
// Multiply/divide unit sequencer: launches fixed-latency ops, gates
// hi/lo writes and stalls the D stage while the unit is occupied.
module mdu_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  e_mduop,
   input  logic [3:0]  d_mduop,
   input  logic        req,
   output logic        start,
   output logic        sel_div,
   output logic        busy,
   output logic        commit,
   output logic        wr_hi,
   output logic        wr_lo,
   output logic        stall,
   output logic [3:0]  cnt,
   output logic [31:0] busy_cycles
);

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      DIV
   } state_t;

   state_t state;

   logic is_mul;
   logic is_div;
   logic issue;
   logic d_mdu;

   assign is_mul = (e_mduop == 4'd1) || (e_mduop == 4'd2);
   assign is_div = (e_mduop == 4'd3) || (e_mduop == 4'd4);

   // Ops in E only act when the unit is free and not being flushed.
   assign issue  = reset && !busy && !req;
   assign start  = issue && (is_mul || is_div);
   assign wr_hi  = issue && (e_mduop == 4'd7);
   assign wr_lo  = issue && (e_mduop == 4'd8);
   assign commit = reset && busy && (cnt == 4'd1);

   assign d_mdu  = (d_mduop >= 4'd1) && (d_mduop <= 4'd8);
   assign stall  = reset && d_mdu && (start || busy);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         busy        <= 1'b0;
         sel_div     <= 1'b0;
         busy_cycles <= 32'd0;
      end else begin
         if (busy)
            busy_cycles <= busy_cycles + 32'd1;
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  sel_div <= is_div;
                  if (is_div) begin
                     state <= DIV;
                     cnt   <= 4'(DIV_LAT);
                  end else begin
                     state <= MULT;
                     cnt   <= 4'(MULT_LAT);
                  end
               end
            end
            MULT, DIV: begin
               if (cnt > 4'd1) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state   <= IDLE;
                  cnt     <= 4'd0;
                  busy    <= 1'b0;
                  sel_div <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= 4'd0;
               busy    <= 1'b0;
               sel_div <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: cycle-numbered reference model plus a commit
// scoreboard; directed scenarios followed by random traffic.
module tb_mdu_ctrl;

   localparam int ML = 5;
   localparam int DL = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  e_mduop = 4'd0;
   logic [3:0]  d_mduop = 4'd0;
   logic        req = 1'b0;
   logic        start, sel_div, busy, commit;
   logic        wr_hi, wr_lo, stall;
   logic [3:0]  cnt;
   logic [31:0] busy_cycles;

   mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk(clk), .reset(reset),
      .e_mduop(e_mduop), .d_mduop(d_mduop), .req(req),
      .start(start), .sel_div(sel_div), .busy(busy),
      .commit(commit), .wr_hi(wr_hi), .wr_lo(wr_lo),
      .stall(stall), .cnt(cnt), .busy_cycles(busy_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit div;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;

   // Preload handshake for the busy-cycle counter model.
   int          bc_load_seq = 0;
   logic [31:0] bc_load_val = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Model: an op occupies the cycles after its launch up to and
   // including launch+latency; everything else follows from that.
   bit          active = 0;
   int          op_start = 0;
   int          op_end = 0;
   bit          op_div = 0;
   int          bc_seen = 0;
   logic [31:0] bc_model = 32'd0;

   always @(negedge clk) begin
      bit eb, es, ec, mdu_d;
      int rem;
      if (bc_load_seq != bc_seen) begin
         bc_model = bc_load_val;
         bc_seen = bc_load_seq;
      end
      if (!reset) begin
         active = 0;
         sb.delete();
         bc_model = 32'd0;
         chk("rst_start", start, 0);
         chk("rst_busy", busy, 0);
         chk("rst_seldiv", sel_div, 0);
         chk("rst_commit", commit, 0);
         chk("rst_wrhi", wr_hi, 0);
         chk("rst_wrlo", wr_lo, 0);
         chk("rst_stall", stall, 0);
         chk("rst_cnt", cnt, 0);
         chk("rst_bc", busy_cycles, 0);
      end else begin
         eb = active && cyc > op_start && cyc <= op_end;
         ec = eb && cyc == op_end;
         rem = eb ? op_end - cyc + 1 : 0;
         es = !eb && !req && e_mduop >= 1 && e_mduop <= 4;
         mdu_d = d_mduop >= 1 && d_mduop <= 8;
         chk("start", start, es);
         chk("busy", busy, eb);
         chk("sel_div", sel_div, eb && op_div);
         chk("commit", commit, ec);
         chk("cnt", cnt, rem);
         chk("wr_hi", wr_hi, !eb && !req && e_mduop == 7);
         chk("wr_lo", wr_lo, !eb && !req && e_mduop == 8);
         chk("stall", stall, mdu_d && (es || eb));
         chk("busy_cycles", busy_cycles, bc_model);
         if (eb) bc_model = bc_model + 32'd1;
         if (ec) active = 0;
         if (es) begin
            active = 1;
            op_div = e_mduop >= 3;
            op_start = cyc;
            op_end = cyc + (op_div ? DL : ML);
            sb.push_back('{cyc: op_end, div: op_div});
         end
      end
   end

   // Monitor: every commit must match the oldest launched op.
   always @(negedge clk) begin
      exp_t e;
      if (reset && commit) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_commit", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("sb_commit_cyc", cyc, e.cyc);
            chk("sb_commit_div", sel_div, e.div);
         end
      end
   end

   task automatic step(input logic [3:0] e, input logic [3:0] d,
                       input logic r);
      @(posedge clk);
      #1;
      e_mduop = e;
      d_mduop = d;
      req = r;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'd0, 4'd0, 1'b0);
   endtask

   task automatic drain;
      int k;
      k = 0;
      while (busy && k < 40) begin
         step(4'd0, 4'd0, 1'b0);
         k++;
      end
      chk("drain_timeout", busy, 0);
   endtask

   initial begin
      idle(3);
      @(posedge clk);
      #1 reset = 1'b1;
      idle(2);

      // mult with fixed latency
      step(4'd1, 4'd0, 1'b0);
      idle(ML + 2);

      // divu with dependent mflo in D
      step(4'd4, 4'd6, 1'b0);
      for (int i = 0; i < DL + 2; i++) step(4'd0, 4'd6, 1'b0);
      idle(1);

      // flushed div and mthi
      step(4'd3, 4'd0, 1'b1);
      step(4'd7, 4'd0, 1'b1);
      idle(2);

      // flush mid-mult, then mtlo
      step(4'd2, 4'd0, 1'b0);
      step(4'd0, 4'd0, 1'b0);
      step(4'd0, 4'd0, 1'b0);
      step(4'd0, 4'd0, 1'b1);
      idle(ML);
      step(4'd8, 4'd0, 1'b0);
      idle(2);

      // async reset during a div
      step(4'd3, 4'd5, 1'b0);
      step(4'd0, 4'd5, 1'b0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("areset_busy", busy, 0);
      chk("areset_cnt", cnt, 0);
      chk("areset_commit", commit, 0);
      chk("areset_stall", stall, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      d_mduop = 4'd0;
      step(4'd2, 4'd0, 1'b0);
      idle(ML + 2);

      // busy-cycle counter wrap
      @(posedge clk);
      #1;
      e_mduop = 4'd0;
      force dut.busy_cycles = 32'hFFFF_FFFE;
      bc_load_val = 32'hFFFF_FFFE;
      bc_load_seq++;
      #1 release dut.busy_cycles;
      step(4'd1, 4'd0, 1'b0);
      idle(ML + 1);
      chk("bc_wrap", busy_cycles, 32'd3);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [3:0] e;
         e = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'($urandom_range(0, 8));
         step(e, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 7) == 0));
      end
      drain();
      idle(2);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, busy cycles for mult/multu (legal 2..15).
REQ-002 SHALL have parameter DIV_LAT, default 10, busy cycles for div/divu (legal 2..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port e_mduop  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none.
REQ-006 SHALL have port d_mduop  input  4  D-stage op, same encoding as e_mduop.
REQ-007 SHALL have port req  input  1  exception/interrupt flush of the E-stage instruction this cycle.
REQ-008 SHALL have port start  output  1  combinational; launch multiply/divide this cycle.
REQ-009 SHALL have port sel_div  output  1  registered; 1 = operation in flight is div/divu.
REQ-010 SHALL have port busy  output  1  registered; operation in flight.
REQ-011 SHALL have port commit  output  1  combinational; write result to hi/lo at the end of this cycle.
REQ-012 SHALL have port wr_hi  output  1  combinational; mthi write enable.
REQ-013 SHALL have port wr_lo  output  1  combinational; mtlo write enable.
REQ-014 SHALL have port stall  output  1  combinational; hold D stage and freeze F/D.
REQ-015 SHALL have port cnt  output  4  registered; remaining busy cycles.
REQ-016 SHALL have port busy_cycles  output  32  registered; count of cycles with busy=1, wraps modulo 2^32.

Function
REQ-017 SHALL implement FSM states IDLE, MULT, DIV; busy = (state != IDLE); sel_div = (state == DIV).
REQ-018 SHALL, in IDLE with req=0 and e_mduop in {1,2}, assert start, load cnt=MULT_LAT, and enter MULT.
REQ-019 SHALL, in IDLE with req=0 and e_mduop in {3,4}, assert start, load cnt=DIV_LAT, and enter DIV.
REQ-020 SHALL, in MULT/DIV with cnt>1, decrement cnt by 1 per cycle and keep commit=0.
REQ-021 SHALL, in MULT/DIV with cnt==1, assert commit for that single cycle, set cnt=0, and return to IDLE.
REQ-022 SHALL give a fixed latency: start in cycle T -> busy=1 in cycles T+1..T+LAT, commit=1 only in T+LAT, busy=0 from T+LAT+1.
REQ-023 SHALL, in IDLE with req=0, drive wr_hi=(e_mduop==7) and wr_lo=(e_mduop==8); both SHALL be 0 otherwise.
REQ-024 SHALL hold start, wr_hi and wr_lo at 0 whenever req=1, leaving state and cnt unchanged that cycle.
REQ-025 SHALL NOT abort an in-flight operation on req; commit SHALL still occur at T+LAT.
REQ-026 SHALL ignore e_mduop while busy (no second start, no wr_hi/wr_lo); stall guarantees that no MDU op reaches E while busy.
REQ-027 SHALL drive stall = (d_mduop in 1..8) AND (start OR busy); stall SHALL be 0 during ops 0 and 9-15.
REQ-028 SHALL release stall in the cycle after commit, so a following mfhi/mflo reads the committed hi/lo.
REQ-029 SHALL increment busy_cycles on each rising edge where busy=1, wrapping 0xFFFFFFFF -> 0.
REQ-030 SHALL treat e_mduop 5/6 (mfhi/mflo) as no FSM action; read muxing is outside this block.

Reset
REQ-031 SHALL, while reset=0, asynchronously force state=IDLE, cnt=0, busy=0, sel_div=0, and busy_cycles=0.
REQ-032 SHALL, while reset=0, hold start, commit, wr_hi, wr_lo and stall at 0.
REQ-033 SHALL, on reset assertion mid-operation, drop the operation without commit; the first edge after release SHALL see IDLE.

Verification
REQ-034 SHALL cover: e_mduop=1 at T, req=0 -> start=1 at T; busy=1 for T+1..T+5; commit=1 only at T+5; cnt 5,4,3,2,1 -> 0.
REQ-035 SHALL cover: e_mduop=4 at T, d_mduop=6 -> stall=1 for T..T+10, stall=0 at T+11; busy_cycles +10.
REQ-036 SHALL cover: e_mduop=3 with req=1 -> start=0, busy stays 0; e_mduop=7 with req=1 -> wr_hi=0.
REQ-037 SHALL cover: req=1 at T+3 of a mult -> commit still at T+5; e_mduop=8 in IDLE -> wr_lo=1 for one cycle.
REQ-038 SHALL cover: reset=0 asynchronously at T+2 of a div -> busy=0 and cnt=0 immediately with no commit; after release, e_mduop=2 -> normal 5-cycle sequence.
REQ-039 SHALL cover: busy_cycles preloaded to 0xFFFFFFFE via force and one mult run -> value wraps to 3 after 5 busy cycles.
